// File: rtl/aes_byte_loader.sv
// Byte-stream front end for the AES-128 encryption controller: gathers key and plaintext bytes, starts the core, streams the cipher back.
// Optional build macro AES_BYTE_LOADER_KEY_REUSE_EN keeps the key across frames so later frames carry plaintext only.
module aes_byte_loader #(
    parameter int TIMEOUT_CICLOS  = 4096,
    parameter int LARGURA_TIMEOUT = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_byte,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [127:0] chave,
    output logic [127:0] palavra,
    output logic         start,
    input  logic [127:0] cifra,
    input  logic         done,
    output logic         busy,
    output logic         erro
);

    localparam logic [2:0] RX_CHAVE   = 3'd0;
    localparam logic [2:0] RX_PALAVRA = 3'd1;
    localparam logic [2:0] DISPARO    = 3'd2;
    localparam logic [2:0] ESPERA     = 3'd3;
    localparam logic [2:0] TX         = 3'd4;

    // The DISPARO cycle counts as the first timeout cycle, so erro rises
    // exactly TIMEOUT_CICLOS cycles after the start pulse.
    localparam logic [LARGURA_TIMEOUT-1:0] LIMITE = LARGURA_TIMEOUT'(TIMEOUT_CICLOS - 2);

    logic [2:0]                 state;
    logic [3:0]                 cnt;
    logic [LARGURA_TIMEOUT-1:0] tmo;
    logic [127:0]               cifra_reg;
    logic [6:0]                 base;
    logic                       rx_fire;
    logic                       tx_fire;
    logic [2:0]                 after_tx;

`ifdef AES_BYTE_LOADER_KEY_REUSE_EN
    logic chave_ok;
    assign after_tx = chave_ok ? RX_PALAVRA : RX_CHAVE;
`else
    assign after_tx = RX_CHAVE;
`endif

    // Byte k lands at bit offset 8*(15-k); ~cnt is 15-cnt for a 4-bit count.
    assign base     = {~cnt, 3'b000};
    assign rx_ready = !rst && (state == RX_CHAVE || state == RX_PALAVRA);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_valid = (state == TX);
    assign tx_fire  = tx_valid && tx_ready;
    assign tx_byte  = cifra_reg[base +: 8];
    assign start    = (state == DISPARO);
    assign busy     = (state == DISPARO) || (state == ESPERA) || (state == TX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_CHAVE;
            cnt       <= 4'd0;
            tmo       <= '0;
            chave     <= '0;
            palavra   <= '0;
            cifra_reg <= '0;
            erro      <= 1'b0;
`ifdef AES_BYTE_LOADER_KEY_REUSE_EN
            chave_ok  <= 1'b0;
`endif
        end else begin
            if (rx_fire) begin
                erro <= 1'b0;
            end
            case (state)
                RX_CHAVE: begin
                    if (rx_fire) begin
                        chave[base +: 8] <= rx_byte;
                        cnt              <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= RX_PALAVRA;
                        end
                    end
                end
                RX_PALAVRA: begin
                    if (rx_fire) begin
                        palavra[base +: 8] <= rx_byte;
                        cnt                <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= DISPARO;
                        end
                    end
                end
                DISPARO: begin
                    tmo   <= '0;
                    state <= ESPERA;
                end
                ESPERA: begin
                    if (done) begin
                        cifra_reg <= cifra;
                        cnt       <= 4'd0;
                        state     <= TX;
`ifdef AES_BYTE_LOADER_KEY_REUSE_EN
                        chave_ok  <= 1'b1;
`endif
                    end else if (tmo == LIMITE) begin
                        erro  <= 1'b1;
                        cnt   <= 4'd0;
                        state <= RX_CHAVE;
`ifdef AES_BYTE_LOADER_KEY_REUSE_EN
                        chave_ok <= 1'b0;
`endif
                    end else begin
                        tmo <= tmo + LARGURA_TIMEOUT'(1);
                    end
                end
                TX: begin
                    if (tx_fire) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= after_tx;
                        end
                    end
                end
                default: begin
                    state <= RX_CHAVE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
